// File: rtl/game_pkg.sv
// Shared constants for the screen sequencer: default geometry/timing and FSM state encodings.
package game_pkg;

   localparam int DEF_NUM_FRAMES  = 3;
   localparam int DEF_SCREEN_W    = 160;
   localparam int DEF_SCREEN_H    = 120;
   localparam int DEF_TICK_CYCLES = 12500000;
   localparam int DEF_LOOP        = 1;

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] LOAD   = 3'd1;
   localparam logic [2:0] DRAW   = 3'd2;
   localparam logic [2:0] HOLD   = 3'd3;
   localparam logic [2:0] CHOSEN = 3'd4;

endpackage

// File: rtl/frame_tick.sv
// Frame-period counter: counts 0..TICK_CYCLES-1 while enabled and flags the last count.
// A clear restarts the period so the cycle after the clear reads zero.
module frame_tick
   import game_pkg::*;
#(
   parameter int TICK_CYCLES = DEF_TICK_CYCLES
) (
   input  logic clk,
   input  logic stateReset,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int CW = $clog2(TICK_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

   logic [CW-1:0] count;

   // Period counter: restart on clear, wrap after the terminal count.
   always_ff @(posedge clk) begin
      if (stateReset || clear) begin
         count <= '0;
      end else if (enable) begin
         count <= (count == LAST) ? '0 : count + 1'b1;
      end
   end

   assign expire = enable && (count == LAST);

endmodule

// File: rtl/screen_sequencer.sv
// Cycles through title/choose screens: each frame is drawn pixel by pixel into a frame
// buffer, then held until the frame period elapses or the user selects it.
//
// state  | meaning
// IDLE   | waiting for start, outputs quiet
// LOAD   | one cycle: pixel cursor, tick counter and pending flags reset
// DRAW   | one pixel written per cycle, raster order
// HOLD   | frame shown; select -> CHOSEN, tick -> next frame
// CHOSEN | one cycle: chosen pulse, chosenFrame latched
module screen_sequencer
   import game_pkg::*;
#(
   parameter int NUM_FRAMES  = DEF_NUM_FRAMES,
   parameter int SCREEN_W    = DEF_SCREEN_W,
   parameter int SCREEN_H    = DEF_SCREEN_H,
   parameter int TICK_CYCLES = DEF_TICK_CYCLES,
   parameter int LOOP        = DEF_LOOP
) (
   input  logic                                   clk,
   input  logic                                   stateReset,
   input  logic                                   start,
   input  logic                                   userSel,
   output logic [$clog2(SCREEN_W)-1:0]            x,
   output logic [$clog2(SCREEN_H)-1:0]            y,
   output logic [$clog2(SCREEN_W*SCREEN_H)-1:0]   address,
   output logic [$clog2(NUM_FRAMES)-1:0]          frameSel,
   output logic                                   plot,
   output logic                                   chosen,
   output logic [$clog2(NUM_FRAMES)-1:0]          chosenFrame,
   output logic                                   busy
);

   localparam int XW = $clog2(SCREEN_W);
   localparam int YW = $clog2(SCREEN_H);
   localparam int FW = $clog2(NUM_FRAMES);

   localparam logic [XW-1:0] X_LAST = XW'(SCREEN_W - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(SCREEN_H - 1);
   localparam logic [FW-1:0] F_LAST = FW'(NUM_FRAMES - 1);

   logic [2:0] state;
   logic [2:0] nextState;
   logic       selPending;
   logic       tickPending;
   logic       tickExpire;
   logic       lastPixel;
   logic       lastFrameStuck;

   assign lastPixel      = (x == X_LAST) && (y == Y_LAST);
   // Without looping the last frame is terminal: only a select can leave it.
   assign lastFrameStuck = (LOOP == 0) && (frameSel == F_LAST);

   // The tick restarts on every entry to LOAD so LOAD itself is count zero of the period.
   frame_tick #(
      .TICK_CYCLES (TICK_CYCLES)
   ) uTick (
      .clk        (clk),
      .stateReset (stateReset),
      .clear      (nextState == LOAD),
      .enable     (state != IDLE),
      .expire     (tickExpire)
   );

   // Next-state decision; select outranks tick in HOLD.
   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (start) nextState = LOAD;
         LOAD:    nextState = DRAW;
         DRAW:    if (lastPixel) nextState = HOLD;
         HOLD: begin
            if (selPending || userSel) begin
               nextState = CHOSEN;
            end else if ((tickExpire || tickPending) && !lastFrameStuck) begin
               nextState = LOAD;
            end
         end
         CHOSEN:  nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (stateReset) state <= IDLE;
      else            state <= nextState;
   end

   // Pixel cursor: zeroed on the way into LOAD, walked in raster order during DRAW.
   // Address is stepped alongside x/y instead of computing y*SCREEN_W+x.
   always_ff @(posedge clk) begin
      if (stateReset) begin
         x       <= '0;
         y       <= '0;
         address <= '0;
      end else if (nextState == LOAD) begin
         x       <= '0;
         y       <= '0;
         address <= '0;
      end else if ((state == DRAW) && !lastPixel) begin
         address <= address + 1'b1;
         if (x == X_LAST) begin
            x <= '0;
            y <= y + 1'b1;
         end else begin
            x <= x + 1'b1;
         end
      end
   end

   // Frame index: zero on start, advanced (with wrap) when HOLD moves on to the next frame.
   always_ff @(posedge clk) begin
      if (stateReset) begin
         frameSel <= '0;
      end else if ((state == IDLE) && start) begin
         frameSel <= '0;
      end else if ((state == HOLD) && (nextState == LOAD)) begin
         frameSel <= (frameSel == F_LAST) ? '0 : frameSel + 1'b1;
      end
   end

   // Pending flags remember events that arrive while a frame is still being drawn.
   // A select in LOAD wins over the LOAD-time clear so it is not lost.
   always_ff @(posedge clk) begin
      if (stateReset) begin
         selPending  <= 1'b0;
         tickPending <= 1'b0;
      end else begin
         if (((state == LOAD) || (state == DRAW)) && userSel) selPending <= 1'b1;
         else if ((state == LOAD) || (state == CHOSEN) || (state == IDLE)) selPending <= 1'b0;

         if ((state == DRAW) && tickExpire) tickPending <= 1'b1;
         else if ((state == LOAD) || (state == IDLE)) tickPending <= 1'b0;
      end
   end

   // Chosen frame is captured on entry to CHOSEN so it is already valid during the pulse.
   always_ff @(posedge clk) begin
      if (stateReset)               chosenFrame <= '0;
      else if (nextState == CHOSEN) chosenFrame <= frameSel;
   end

   assign plot   = (state == DRAW);
   assign chosen = (state == CHOSEN);
   assign busy   = (state != IDLE);

endmodule
